// File: rtl/decoder_pkg.sv
// Shared code parameters for the K=3 rate-1/2 convolutional code.
// Holds generators, trellis sizes, metric/survivor types and helpers.
package decoder_pkg;

  localparam int K = 3;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
  localparam int NSTATES = 1 << (K - 1);
  localparam int TB_DEPTH = 16;
  localparam int PM_W = 5;

  typedef logic [PM_W-1:0] pm_t;
  typedef logic [TB_DEPTH-1:0] surv_t;

  // st = {s1,s0}; taps ordered {d,s0,s1}
  function automatic logic [1:0] enc_sym(
    input logic       d,
    input logic [1:0] st
  );
    logic [2:0] r;
    r = {d, st[0], st[1]};
    enc_sym = {^(r & G0), ^(r & G1)};
  endfunction

  function automatic logic [1:0] hdist(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [1:0] x;
    x = a ^ b;
    hdist = {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/acs_unit.sv
// Add-compare-select for one trellis state with survivor update.
// Ports: rx, d, pm_a/pm_b, sv_a/sv_b, sym_a/sym_b -> pm, sv.
import decoder_pkg::*;

module acs_unit (
  input  logic [1:0] rx,
  input  logic       d,
  input  pm_t        pm_a,
  input  pm_t        pm_b,
  input  surv_t      sv_a,
  input  surv_t      sv_b,
  input  logic [1:0] sym_a,
  input  logic [1:0] sym_b,
  output pm_t        pm,
  output surv_t      sv
);

  pm_t  c_a;
  pm_t  c_b;
  logic sel_b;

  assign c_a = pm_a + pm_t'(hdist(rx, sym_a));
  assign c_b = pm_b + pm_t'(hdist(rx, sym_b));
  // strict compare: ties keep predecessor a
  assign sel_b = c_b < c_a;
  assign pm = sel_b ? c_b : c_a;
  assign sv = sel_b ? {sv_b[TB_DEPTH-2:0], d}
                    : {sv_a[TB_DEPTH-2:0], d};

endmodule

// File: rtl/encoder.sv
// Companion rate-1/2 K=3 convolutional encoder, 1-cycle latency.
// Ports: clk, rst (async low), enable_i, d_in -> valid_o, d_out.
import decoder_pkg::*;

module encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       valid_o,
  output logic [1:0] d_out
);

  logic [1:0] st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= 2'b00;
      d_out   <= 2'b00;
      valid_o <= 1'b0;
    end else begin
      valid_o <= enable_i;
      if (enable_i) begin
        d_out <= enc_sym(d_in, st);
        st    <= {st[0], d_in};
      end else begin
        d_out <= 2'b00;
      end
    end
  end

endmodule

// File: rtl/decoder.sv
// 4-state hard-decision Viterbi decoder, register-exchange survivors.
// Ports: clk, rst (async low), enable, d_in[1:0] -> d_out (registered).
import decoder_pkg::*;

module decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  pm_t   pm_q [NSTATES];
  pm_t   pm_n [NSTATES];
  surv_t sv_q [NSTATES];
  surv_t sv_n [NSTATES];
  pm_t   pm_min;
  logic [1:0] best;

  // new state {s0,d}: predecessors {0,s0} and {1,s0}
  for (genvar n = 0; n < NSTATES; n++) begin : g_acs
    localparam int S0 = (n >> 1) & 1;
    localparam logic [1:0] PA = 2'(S0);
    localparam logic [1:0] PB = 2'(S0) | 2'b10;
    localparam logic D = 1'(n & 1);

    acs_unit u_acs (
      .rx    (d_in),
      .d     (D),
      .pm_a  (pm_q[PA]),
      .pm_b  (pm_q[PB]),
      .sv_a  (sv_q[PA]),
      .sv_b  (sv_q[PB]),
      .sym_a (enc_sym(D, PA)),
      .sym_b (enc_sym(D, PB)),
      .pm    (pm_n[n]),
      .sv    (sv_n[n])
    );
  end

  // lowest index wins on equal metrics
  always_comb begin
    pm_min = pm_n[0];
    best   = 2'd0;
    for (int i = 1; i < NSTATES; i++) begin
      if (pm_n[i] < pm_min) begin
        pm_min = pm_n[i];
        best   = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSTATES; i++) begin
        pm_q[i] <= (i == 0) ? pm_t'(0) : pm_t'(16);
        sv_q[i] <= '0;
      end
      d_out <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < NSTATES; i++) begin
        pm_q[i] <= pm_n[i] - pm_min;
        sv_q[i] <= sv_n[i];
      end
      d_out <= sv_n[best][TB_DEPTH-1];
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Bench for encoder -> decoder chain against a delayed-stream model.
// Drives encoder, feeds its registered output into the decoder.
module tb_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_en;
  logic       enc_d;
  logic       err;
  logic       enc_valid;
  logic [1:0] enc_dout;
  logic       dec_en;
  logic [1:0] dec_din;
  logic       dec_out;

  assign dec_en  = enc_valid;
  assign dec_din = enc_dout ^ {1'b0, err};

  always #5 clk = ~clk;

  encoder u_enc (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enc_en),
    .d_in     (enc_d),
    .valid_o  (enc_valid),
    .d_out    (enc_dout)
  );

  decoder dut (
    .clk    (clk),
    .rst    (rst),
    .enable (dec_en),
    .d_in   (dec_din),
    .d_out  (dec_out)
  );

  int n_asserts = 0;
  int n_fails   = 0;
  bit sent[$];
  int k;
  bit pend;
  bit m_s0;
  bit m_s1;
  bit err_mode;
  bit stream[256];
  logic [1:0] tbl[4];

  task automatic chk(input string tag, input logic [1:0] obs,
                     input logic [1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sent.delete();
    k    = 0;
    pend = 1'b0;
    m_s0 = 1'b0;
    m_s1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    enc_en = 1'b0;
    enc_d  = 1'b0;
    err    = 1'b0;
    #1;
    chk("rst_async_dout", {1'b0, dec_out}, 2'b00);
    chk("rst_enc_dout", enc_dout, 2'b00);
    chk("rst_enc_valid", {1'b0, enc_valid}, 2'b00);
    @(negedge clk);
    chk("rst_hold_dout", {1'b0, dec_out}, 2'b00);
    rst = 1'b1;
    model_reset();
  endtask

  // one clock: encoder input b with enable en; the decoder sees
  // last cycle's encoder symbol, optionally corrupted in bit 0
  task automatic step(input bit en, input bit b);
    bit [1:0] esym;
    bit       eexp;
    int       j;
    @(negedge clk);
    enc_en = en;
    enc_d  = b;
    j = (k + 1) % 16;
    err = err_mode && pend && (j == 6 || j == 7);
    @(posedge clk);
    #1;
    if (pend) k++;
    eexp = (k <= 15) ? 1'b0 : sent[k-16];
    chk("dec_dout", {1'b0, dec_out}, {1'b0, eexp});
    if (en) begin
      esym = {b ^ m_s0 ^ m_s1, b ^ m_s1};
      m_s1 = m_s0;
      m_s0 = b;
      sent.push_back(b);
    end else begin
      esym = 2'b00;
    end
    chk("enc_dout", enc_dout, esym);
    chk("enc_valid", {1'b0, enc_valid}, {1'b0, en});
    pend = en;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    enc_en   = 1'b0;
    enc_d    = 1'b0;
    err      = 1'b0;
    err_mode = 1'b0;
    tbl[0] = 2'b11;
    tbl[1] = 2'b10;
    tbl[2] = 2'b00;
    tbl[3] = 2'b01;
    foreach (stream[i]) stream[i] = 1'($urandom);
    model_reset();

    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0);
      chk("zero_enc", enc_dout, 2'b00);
      chk("zero_dec", {1'b0, dec_out}, 2'b00);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 1) ? 1'b0 : 1'b1);
      chk("enc_seq", enc_dout, tbl[i]);
    end

    do_reset();
    for (int i = 0; i < 256; i++) step(1'b1, stream[i]);
    step(1'b0, 1'b0);

    do_reset();
    err_mode = 1'b1;
    for (int i = 0; i < 256; i++) step(1'b1, stream[i]);
    step(1'b0, 1'b0);
    err_mode = 1'b0;

    do_reset();
    for (int i = 0; sent.size() < 64; i++) begin
      if ((i % 4) == 0 || (i % 4) == 3)
        step(1'b1, stream[sent.size()]);
      else
        step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    chk("pre_rst_one", {1'b0, dec_out}, 2'b01);
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, stream[100 + i]);
    step(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 The decoder SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The decoder SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The decoder SHALL have port enable, input, 1 bit: when high, d_in is a valid code symbol sampled this edge.
REQ-004 The decoder SHALL have port d_in, input, 2 bits: hard-decision received symbol {g0 bit, g1 bit}.
REQ-005 The decoder SHALL have port d_out, output, 1 bit: decoded data bit, registered.
REQ-006 The companion encoder SHALL have ports clk and rst (same clock and reset as the decoder), enable_i (in, 1), d_in (in, 1), valid_o (out, 1) and d_out (out, 2).

Function
REQ-007 The code SHALL be rate 1/2, K=3, with generators g0=111 and g1=101 (binary), state {s1,s0}, s0 = newest bit.
REQ-008 The encoder SHALL register d_out <= {d^s0^s1, d^s1} and shift the state to {s0,d} on each edge with enable_i=1.
REQ-009 The encoder SHALL register valid_o <= enable_i, giving 1-cycle latency; when enable_i=0 its state holds and d_out <= 2'b00.
REQ-010 The decoder SHALL implement a 4-state hard-decision Viterbi decoder whose trellis matches REQ-007.
REQ-011 The decoder SHALL use as branch metric the Hamming distance (0..2) between d_in and the expected 2-bit symbol.
REQ-012 For each new state {s0,d}, the decoder SHALL do add-compare-select over predecessors {0,s0} and {1,s0}; on a tie, predecessor {0,s0} wins.
REQ-013 The decoder SHALL keep path metrics 5 bits unsigned; after each ACS it subtracts the minimum metric from all four, so that the best metric is 0.
REQ-014 The decoder SHALL keep a register-exchange survivor of depth 16 bits per state: new survivor = {selected predecessor survivor[14:0], d}.
REQ-015 On each enabled edge, the decoder SHALL set d_out <= survivor[15] of the best-metric state after ACS; on a tie, the lowest state index wins.
REQ-016 Latency: the bit of enabled sample n SHALL appear on d_out after enabled sample n+15; for the first 15 samples d_out = 0.
REQ-017 When enable=0, the decoder SHALL hold all metrics, survivors and d_out; gaps in enable do not alter the decoded sequence.
REQ-018 The decoder SHALL correct any pattern of at most 2 bit errors within any 16 consecutive symbols (dfree=5).

Reset
REQ-019 While rst=0, both blocks SHALL be held in their reset state: encoder state 00, d_out 00, valid_o 0; decoder d_out 0 and all survivors 0.
REQ-020 While rst=0, the decoder SHALL set the state-0 metric to 0 and the other metrics to 16.
REQ-021 Assertion of rst mid-stream SHALL abort decoding immediately; after release, the next enabled sample is treated as sample 1.

Structure
REQ-022 A shared package SHALL hold K=3, G0=3'b111, G1=3'b101, NSTATES=4, TB_DEPTH=16 and PM_W=5, plus a typedef for the path-metric type.
REQ-023 The encoder SHALL be a separate module.
REQ-024 Inside the decoder, one sub-module acs_unit (one ACS per state, instantiated 4 times) SHALL be used; everything else is flat.

Verification
REQ-025 Reset then 32 zero bits through encoder and decoder -> encoder d_out always 00, decoder d_out always 0.
REQ-026 Encoder input 1,0,1,1 from state 00 -> encoder d_out sequence 11,10,00,01.
REQ-027 256-bit random stream, encoder output registered one cycle into the decoder -> d_out equals the input stream delayed by 15 enabled samples, zero mismatches.
REQ-028 Same stream with d_in[0] flipped on 2 consecutive symbols in every 16-symbol window -> zero decoded errors.
REQ-029 enable toggled 1,0,0,1 pattern over a 64-bit stream -> decoded sequence identical to the continuous-enable case.
REQ-030 rst pulsed low for 1 cycle at sample 40 -> d_out = 0 immediately; decoding restarts with latency 15 from the next sample.
